program_counter: RTL and testbench

Parameterised program counter for the basic CPU datapath. It sits directly upstream of the d_ff/latch storage layer in the fetch path: it holds the current instruction address in edge-triggered state, presents it to the memory address register, and can drive the shared data bus. It supports increment, absolute load, and an optional signed relative jump, and reports address wrap-around.

---
 rtl/program_counter_if.sv | 28 ++
 rtl/program_counter.sv | 49 ++++
 tb/tb_program_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Control and status bundle for program_counter: step/load controls, bus enable, count and wrap.
// The relative-jump signals exist only when PC_REL_JUMP_EN is defined.
interface program_counter_if #(
  parameter int WIDTH = 8
);
  logic             inc;
  logic             load;
  logic [WIDTH-1:0] din;
`ifdef PC_REL_JUMP_EN
  logic             rel_en;
  logic [WIDTH-1:0] rel_off;
`endif
  logic             oe;
  logic [WIDTH-1:0] count;
  logic             wrap;

  // There is no valid/ready handshake here: every control is a level that is
  // sampled on the rising clock edge and acted on in that same edge.
  // The controller must hold it stable around the edge. count and wrap
  // are registered, and they reflect the control that was sampled on the previous edge.
`ifdef PC_REL_JUMP_EN
  modport master (output inc, load, din, rel_en, rel_off, oe, input count, wrap);
  modport slave  (input inc, load, din, rel_en, rel_off, oe, output count, wrap);
`else
  modport master (output inc, load, din, oe, input count, wrap);
  modport slave  (input inc, load, din, oe, output count, wrap);
`endif
endinterface

// File: rtl/program_counter.sv
// Fetch-path program counter: reset, absolute load, optional signed relative jump
// (PC_REL_JUMP_EN), increment or hold. It has a registered wrap pulse and a tri-state bus driver.
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  pc,
  output wire [WIDTH-1:0]   bus_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;

`ifdef PC_REL_JUMP_EN
  // The carry out of the unsigned add, XORed with the offset sign, is exactly
  // the signed out-of-range condition. A carry with a negative offset is in range.
  // No carry with a negative offset means a borrow past zero.
  logic [WIDTH:0] rel_sum;
  assign rel_sum = {1'b0, count_q} + {1'b0, pc.rel_off};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (pc.load) begin
      count_q <= pc.din;
      wrap_q  <= 1'b0;
`ifdef PC_REL_JUMP_EN
    end else if (pc.rel_en) begin
      count_q <= rel_sum[WIDTH-1:0];
      wrap_q  <= rel_sum[WIDTH] ^ pc.rel_off[WIDTH-1];
`endif
    end else if (pc.inc) begin
      count_q <= count_q + ONE;
      wrap_q  <= &count_q;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign pc.count = count_q;
  assign pc.wrap  = wrap_q;
  assign bus_out  = pc.oe ? count_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases and then randomized control
// sequences. Everything is checked against an integer-arithmetic reference model.
module tb_program_counter;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  wire  [W-1:0] bus_out;

  program_counter_if #(.WIDTH(W)) pc_if ();

  program_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .pc      (pc_if),
    .bus_out (bus_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_count  = 0;
  int m_wrap   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the priority rules, evaluated with plain integer arithmetic.
  task automatic model_step();
    int s;
    if (!reset) begin
      m_count = 0; m_wrap = 0;
    end else if (pc_if.load) begin
      m_count = int'(pc_if.din); m_wrap = 0;
`ifdef PC_REL_JUMP_EN
    end else if (pc_if.rel_en) begin
      s = m_count + int'($signed(pc_if.rel_off));
      m_wrap  = (s < 0 || s >= MOD) ? 1 : 0;
      m_count = (s + MOD) % MOD;
`endif
    end else if (pc_if.inc) begin
      s = m_count + 1;
      m_wrap  = (s == MOD) ? 1 : 0;
      m_count = s % MOD;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".count"}, 32'(pc_if.count), 32'(m_count));
    check({tag, ".wrap"}, 32'(pc_if.wrap), 32'(m_wrap));
    if (pc_if.oe) check({tag, ".bus"}, 32'(bus_out), 32'(m_count));
  endtask

  task automatic idle();
    reset = 1'b1; pc_if.inc = 1'b0; pc_if.load = 1'b0; pc_if.din = '0; pc_if.oe = 1'b0;
`ifdef PC_REL_JUMP_EN
    pc_if.rel_en = 1'b0; pc_if.rel_off = '0;
`endif
  endtask

  task automatic do_load(input logic [W-1:0] v, input string tag);
    idle(); pc_if.load = 1'b1; pc_if.din = v;
    tick(tag);
    pc_if.load = 1'b0;
  endtask

  initial begin
    idle();
    // Reset, with the bus enabled so that the reset value shows on bus_out.
    reset = 1'b0; pc_if.oe = 1'b1;
    tick("reset");
    check("reset_const", 32'(pc_if.count), 32'h0);

    // Count up from zero.
    idle();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pc_if.inc = 1'b1;
    foreach (exp_q[i]) begin
      tick("count_up");
      check("count_up_const", 32'(pc_if.count), 32'(exp_q[i]));
    end

    // Wrap-around: the wrap pulse appears only in the cycle in which count is 00.
    do_load(8'hFE, "wrap_load");
    pc_if.inc = 1'b1;
    exp_q = '{8'hFF, 8'h00, 8'h01};
    foreach (exp_q[i]) begin
      tick("wrap_seq");
      check("wrap_pulse", 32'(pc_if.wrap), (exp_q[i] == 8'h00) ? 32'h1 : 32'h0);
    end

    // Priority: load beats inc, and reset beats load.
    idle(); pc_if.load = 1'b1; pc_if.inc = 1'b1; pc_if.din = 8'h40;
    tick("prio_load_inc");
    check("prio_load_inc_const", 32'(pc_if.count), 32'h40);
    reset = 1'b0; pc_if.din = 8'h77;
    tick("prio_reset_load");
    check("prio_reset_const", 32'(pc_if.count), 32'h0);

    // Bus tri-state: bus_out follows oe with no clock edge in between.
    do_load(8'h3C, "bus_load");
    pc_if.oe = 1'b1; #1;
    check("bus_on", 32'(bus_out), 32'h3C);
    pc_if.oe = 1'b0; #1;
    check("bus_released", 32'(bus_out !== 8'h3C), 32'h1);
    check("bus_count_hold", 32'(pc_if.count), 32'h3C);

`ifdef PC_REL_JUMP_EN
    do_load(8'h10, "rel_load1");
    pc_if.rel_en = 1'b1; pc_if.rel_off = 8'hF8;
    tick("rel_back");
    check("rel_back_const", 32'(pc_if.count), 32'h08);
    do_load(8'h04, "rel_load2");
    pc_if.rel_en = 1'b1; pc_if.rel_off = 8'hF8;
    tick("rel_under");
    check("rel_under_wrap", 32'(pc_if.wrap), 32'h1);
    check("rel_under_count", 32'(pc_if.count), 32'hFC);
`endif

    // A reset in the middle of counting, with inc still held.
    do_load(8'h05, "mid_load");
    pc_if.inc = 1'b1; reset = 1'b0;
    tick("mid_reset");
    reset = 1'b1;
    exp_q = '{8'h01, 8'h02};
    foreach (exp_q[i]) begin
      tick("mid_count");
      check("mid_count_const", 32'(pc_if.count), 32'(exp_q[i]));
    end

    // Randomized controls. Loads land near the top of the range to exercise wrap often.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 31) != 0);
      pc_if.inc = $urandom_range(0, 3) != 0;
      pc_if.load = ($urandom_range(0, 7) == 0);
      pc_if.din = ($urandom_range(0, 1) != 0) ? W'($urandom_range(MOD - 4, MOD - 1))
                                               : W'($urandom);
      pc_if.oe  = $urandom_range(0, 1) != 0;
`ifdef PC_REL_JUMP_EN
      pc_if.rel_en  = ($urandom_range(0, 3) == 0);
      pc_if.rel_off = W'($urandom);
`endif
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
